sram_ctrl: RTL and testbench

- Synchronous initiator for the external 8-bit asynchronous SRAM (512K x 8, active-low CE/OE/WE, 19-bit address).
- Converts single-beat byte/halfword/word requests from the on-chip bus into a sequence of byte-wide SRAM read or write cycles.
- Sits between the bus interconnect and the SRAM pads. Its pin side connects directly to the SRAM simulation model.

---
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Byte-serial initiator for an 8-bit asynchronous SRAM: each bus request becomes N byte cycles
// of SETUP / ACCESS(WAIT_CYCLES) / HOLD, followed by a one-cycle DONE ack. All pin outputs are flops.
module sram_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  output logic              s_rdy,
  input  logic              s_we,
  input  logic [1:0]        s_size,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic [31:0]       s_rdata,
  output logic              s_ack,
  output logic              sram_ce_bar,
  output logic              sram_oe_bar,
  output logic              sram_we_bar,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [7:0]        sram_data
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        k_q, k_d;
  logic [3:0]        wait_q, wait_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              ce_bar_q, ce_bar_d;
  logic              oe_bar_q, oe_bar_d;
  logic              we_bar_q, we_bar_d;
  logic              drv_q, drv_d;
  logic [ADDR_W-1:0] pin_addr_q, pin_addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [31:0]       rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      rbuf_q     <= '0;
      ce_bar_q   <= 1'b1;
      oe_bar_q   <= 1'b1;
      we_bar_q   <= 1'b1;
      drv_q      <= 1'b0;
      pin_addr_q <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      rbuf_q     <= rbuf_d;
      ce_bar_q   <= ce_bar_d;
      oe_bar_q   <= oe_bar_d;
      we_bar_q   <= we_bar_d;
      drv_q      <= drv_d;
      pin_addr_q <= pin_addr_d;
      dout_q     <= dout_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    k_d     = k_q;
    wait_d  = wait_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (s_req) begin
          state_d = SETUP;
          we_d    = s_we;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          last_d  = (s_size == 2'd0) ? 2'd0 : (s_size == 2'd1) ? 2'd1 : 2'd3;
          k_d     = 2'd0;
          rbuf_d  = '0;  // unread upper bytes stay zero
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) rbuf_d[8*k_q +: 8] = sram_data;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HOLD: begin
        if (k_q != last_q) begin
          k_d     = k_q + 2'd1;
          state_d = SETUP;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so they land in flops on the same edge.
  always_comb begin
    ce_bar_d   = 1'b1;
    oe_bar_d   = 1'b1;
    we_bar_d   = 1'b1;
    drv_d      = 1'b0;
    pin_addr_d = pin_addr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    case (state_d)
      SETUP: begin
        ce_bar_d   = 1'b0;
        drv_d      = we_d;
        pin_addr_d = addr_d + ADDR_W'(k_d);
        dout_d     = wdata_d[8*k_d +: 8];
      end
      ACCESS: begin
        ce_bar_d = 1'b0;
        oe_bar_d = we_d;
        we_bar_d = !we_d;
        drv_d    = we_d;
      end
      HOLD: begin
        ce_bar_d = 1'b0;
        drv_d    = we_d;
      end
      DONE: begin
        if (!we_d) rdata_d = rbuf_d;
      end
      default: ;
    endcase
  end

  assign s_rdy       = (state_q == IDLE);
  assign s_ack       = (state_q == DONE);
  assign s_rdata     = rdata_q;
  assign sram_ce_bar = ce_bar_q;
  assign sram_oe_bar = oe_bar_q;
  assign sram_we_bar = we_bar_q;
  assign sram_addr   = pin_addr_q;
  assign sram_data   = drv_q ? dout_q : 8'bz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 2, 1, 3), each with its own SRAM model
// and pin-timing monitor; expected data comes from a byte-array reference memory.
module tb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        s_req   [3];
  logic        s_we    [3];
  logic [1:0]  s_size  [3];
  logic [18:0] s_addr  [3];
  logic [31:0] s_wdata [3];
  logic        s_rdy   [3];
  logic        s_ack   [3];
  logic [31:0] s_rdata [3];
  logic        ce      [3];
  logic        oe      [3];
  logic        web     [3];
  logic [18:0] sa      [3];
  logic [7:0]  sd_mon  [3];
  logic [7:0]  rd_byte [3] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    wire [7:0] sd;
    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (sd[b]);
    end
    assign sd = (!ce[g] && !oe[g]) ? rd_byte[g] : 8'bz;
    assign sd_mon[g] = sd;
    sram_ctrl #(.ADDR_W(19), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .s_req(s_req[g]), .s_rdy(s_rdy[g]), .s_we(s_we[g]), .s_size(s_size[g]),
      .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_rdata(s_rdata[g]), .s_ack(s_ack[g]),
      .sram_ce_bar(ce[g]), .sram_oe_bar(oe[g]), .sram_we_bar(web[g]),
      .sram_addr(sa[g]), .sram_data(sd)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents (device side) and reference contents (bench expectation), keyed by instance and address
  bit [7:0] mem     [int];
  bit [7:0] ref_mem [int];

  function automatic int key(input int i, input int a);
    return (i << 20) + (a % 524288);
  endfunction

  function automatic logic [7:0] mem_get(input int k);
    if (mem.exists(k)) return mem[k];
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_read(input int i, input int a, input int n);
    int v = 0;
    for (int k = 0; k < n; k++)
      if (ref_mem.exists(key(i, a + k))) v = v + int'(ref_mem[key(i, a + k)]) * (1 << (8 * k));
    return 32'(v);
  endfunction

  task automatic ref_write(input int i, input int a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) ref_mem[key(i, a + k)] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  // Pin monitor: pulse widths, stability while WE_bar low, OE/WE exclusion, CE in idle
  int          viol   [3] = '{0, 0, 0};
  int          npulse [3] = '{0, 0, 0};
  int          nack   [3] = '{0, 0, 0};
  int          lowc   [3] = '{0, 0, 0};
  logic [18:0] a0     [3];
  logic [7:0]  d0     [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        lowc[i] = 0;
      end else begin
        if (!oe[i] && !web[i]) viol[i]++;
        if (s_rdy[i] && !ce[i]) viol[i]++;
        if (s_ack[i]) nack[i]++;
        if (!oe[i] || !web[i]) begin
          if (lowc[i] == 0) begin
            a0[i] = sa[i];
            d0[i] = sd_mon[i];
          end else if (!web[i] && (sa[i] !== a0[i] || sd_mon[i] !== d0[i])) begin
            viol[i]++;
          end
          if (!oe[i] && $isunknown(sd_mon[i])) viol[i]++;
          lowc[i]++;
        end else if (lowc[i] != 0) begin
          if (lowc[i] != wc(i)) viol[i]++;
          npulse[i]++;
          lowc[i] = 0;
        end
        if (!ce[i] && !web[i]) mem[key(i, int'(sa[i]))] = sd_mon[i];
      end
      rd_byte[i] = mem_get(key(i, int'(sa[i])));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] last_rd [3] = '{0, 0, 0};
  int          exp_ack [3] = '{0, 0, 0};

  task automatic xfer(input int i, input logic we, input logic [1:0] sz, input logic [18:0] a,
                      input logic [31:0] wd, output logic [31:0] rd);
    int n, cnt, lat;
    logic [31:0] exp;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp = ref_read(i, int'(a), n);
    @(negedge clk);
    s_we[i] = we; s_size[i] = sz; s_addr[i] = a; s_wdata[i] = wd; s_req[i] = 1'b1;
    cnt = 0;
    while (!s_rdy[i] && cnt < 200) begin @(negedge clk); cnt++; end
    @(negedge clk);
    // scramble the bus inputs: the controller must work from its latched copy
    s_req[i] = 1'b0; s_we[i] = !we; s_size[i] = 2'($urandom);
    s_addr[i] = 19'($urandom); s_wdata[i] = $urandom;
    lat = 1;
    while (!s_ack[i] && lat < 200) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(n * (wc(i) + 2) + 1));
    rd = s_rdata[i];
    if (we) begin
      chk("rdata_kept_on_write", rd, last_rd[i]);
      ref_write(i, int'(a), n, wd);
    end else begin
      chk("rdata", rd, exp);
      last_rd[i] = exp;
    end
    exp_ack[i]++;
    @(negedge clk);
    chk("ack_one_cycle", 32'(s_ack[i]), 32'd0);
    chk("rdy_back", 32'(s_rdy[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        wr;
    logic [18:0] a;
    logic [31:0] wd;
    int          cnt, lat, busy_rdy, ackseen;

    for (int i = 0; i < 3; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_size[i] = 2'd0; s_addr[i] = '0; s_wdata[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(s_rdy[0]), 32'd1);
    chk("rst_ack", 32'(s_ack[0]), 32'd0);
    chk("rst_ce", 32'(ce[0]), 32'd1);
    chk("rst_oe", 32'(oe[0]), 32'd1);
    chk("rst_we", 32'(web[0]), 32'd1);
    chk("rst_addr", 32'(sa[0]), 32'd0);
    chk("rst_rdata", s_rdata[0], 32'd0);
    chk("rst_data_released", 32'(sd_mon[0]), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(s_rdy[0]), 32'd1);

    // Reset in the middle of a word write
    s_we[0] = 1'b1; s_size[0] = 2'd2; s_addr[0] = 19'h00200; s_wdata[0] = 32'h11223344; s_req[0] = 1'b1;
    @(negedge clk);
    s_req[0] = 1'b0;
    chk("setup_ce", 32'(ce[0]), 32'd0);
    chk("setup_wdata", 32'(sd_mon[0]), 32'h44);
    @(negedge clk);
    chk("access_we_low", 32'(web[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(web[0]), 32'd1);
    chk("midrst_ce", 32'(ce[0]), 32'd1);
    chk("midrst_data_released", 32'(sd_mon[0]), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ackseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (s_ack[0]) ackseen = 1;
    end
    chk("midrst_no_ack", 32'(ackseen), 32'd0);
    chk("midrst_rdy", 32'(s_rdy[0]), 32'd1);
    nack[0] = 0;

    // Directed word write / reads
    xfer(0, 1'b1, 2'd2, 19'h00100, 32'hDEADBEEF, rd);
    chk("mem_100_103", {mem_get(key(0, 'h103)), mem_get(key(0, 'h102)),
                        mem_get(key(0, 'h101)), mem_get(key(0, 'h100))}, 32'hDEADBEEF);
    xfer(0, 1'b0, 2'd2, 19'h00100, 32'h0, rd);
    chk("word_read", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 2'd0, 19'h00101, 32'h0, rd);
    chk("byte_read", rd, 32'h000000BE);
    xfer(0, 1'b0, 2'd1, 19'h00101, 32'h0, rd);
    chk("half_read", rd, 32'h0000ADBE);
    xfer(0, 1'b0, 2'd3, 19'h00100, 32'h0, rd);
    chk("size3_read", rd, 32'hDEADBEEF);

    // Address wrap
    xfer(0, 1'b1, 2'd1, 19'h7FFFF, 32'h00001234, rd);
    chk("wrap_mem_7ffff", 32'(mem_get(key(0, 'h7FFFF))), 32'h34);
    chk("wrap_mem_00000", 32'(mem_get(key(0, 'h00000))), 32'h12);
    xfer(0, 1'b0, 2'd2, 19'h7FFFE, 32'h0, rd);
    chk("wrap_word_read", rd, 32'h00123400);

    // Held request with alternating write/read halfwords
    @(negedge clk);
    s_req[0] = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wr = (r % 2 == 0);
      a  = 19'h00300 + 19'(r - (r % 2));
      wd = $urandom;
      s_we[0] = wr; s_size[0] = 2'd1; s_addr[0] = a; s_wdata[0] = wd;
      cnt = 0;
      while (!s_rdy[0] && cnt < 200) begin @(negedge clk); cnt++; end
      lat = 0; busy_rdy = 0;
      do begin
        @(negedge clk);
        lat++;
        if (s_rdy[0]) busy_rdy++;
      end while (!s_ack[0] && lat < 200);
      chk("held_latency", 32'(lat), 32'd9);
      chk("held_rdy_low", 32'(busy_rdy), 32'd0);
      exp_ack[0]++;
      if (wr) begin
        chk("held_rdata_kept", s_rdata[0], last_rd[0]);
        ref_write(0, int'(a), 2, wd);
      end else begin
        chk("held_rdata", s_rdata[0], ref_read(0, int'(a), 2));
        last_rd[0] = ref_read(0, int'(a), 2);
      end
      if (r == 5) s_req[0] = 1'b0;
    end

    // Random traffic around the wrap point on the WAIT_CYCLES=1 and =3 instances
    for (int i = 1; i < 3; i++) begin
      for (int t = 0; t < 40; t++) begin
        a = 19'((32'h7FFEC + $urandom_range(0, 40)) % 524288);
        xfer(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, rd);
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("pin_timing_violations", 32'(viol[i]), 32'd0);
      chk("pulses_seen", 32'(npulse[i] != 0), 32'd1);
      chk("ack_count", 32'(nack[i]), 32'(exp_ack[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
